// File: rtl/register_file_pkg.sv
// Shared constants for the register file: default address and data widths.
package register_file_pkg;

  localparam int RF_AWIDTH = 5;
  localparam int RF_DWIDTH = 32;

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// Register file access bus: one write port and two registered read ports.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int AWIDTH = RF_AWIDTH,
  parameter int DWIDTH = RF_DWIDTH
);

  logic              r_we;
  logic              r_read_reg;
  logic [AWIDTH-1:0] r_addr_rs_1;
  logic [AWIDTH-1:0] r_addr_rs_2;
  logic [AWIDTH-1:0] r_addr_rd;
  logic [DWIDTH-1:0] r_data_rd;
  logic [DWIDTH-1:0] r_data_out_rs1;
  logic [DWIDTH-1:0] r_data_out_rs2;

  modport master (
    output r_we,
    output r_read_reg,
    output r_addr_rs_1,
    output r_addr_rs_2,
    output r_addr_rd,
    output r_data_rd,
    input  r_data_out_rs1,
    input  r_data_out_rs2
  );

  modport slave (
    input  r_we,
    input  r_read_reg,
    input  r_addr_rs_1,
    input  r_addr_rs_2,
    input  r_addr_rd,
    input  r_data_rd,
    output r_data_out_rs1,
    output r_data_out_rs2
  );

endinterface : register_file_if

// File: rtl/register_file.sv
// 2**AWIDTH x DWIDTH register file with register 0 hardwired to zero,
// two registered read ports and write-first bypass.
module register_file
  import register_file_pkg::*;
#(
  parameter int AWIDTH = RF_AWIDTH,
  parameter int DWIDTH = RF_DWIDTH
) (
  input logic             r_clk,
  input logic             r_rst,
  register_file_if.slave  bus
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] regs [DEPTH];
  logic [DWIDTH-1:0] rs1_next;
  logic [DWIDTH-1:0] rs2_next;
  logic [DWIDTH-1:0] rs1_q;
  logic [DWIDTH-1:0] rs2_q;
  logic              write_ok;

  assign write_ok = bus.r_we && (bus.r_addr_rd != '0);

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[bus.r_addr_rd] <= bus.r_data_rd;
    end
  end

  // Address 0 always reads zero; a same-edge write to the read address wins.
  always_comb begin
    rs1_next = regs[bus.r_addr_rs_1];
    rs2_next = regs[bus.r_addr_rs_2];
    if (bus.r_addr_rs_1 == '0) begin
      rs1_next = '0;
    end else if (write_ok && (bus.r_addr_rs_1 == bus.r_addr_rd)) begin
      rs1_next = bus.r_data_rd;
    end
    if (bus.r_addr_rs_2 == '0) begin
      rs2_next = '0;
    end else if (write_ok && (bus.r_addr_rs_2 == bus.r_addr_rd)) begin
      rs2_next = bus.r_data_rd;
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (bus.r_read_reg) begin
      rs1_q <= rs1_next;
      rs2_q <= rs2_next;
    end
  end

  assign bus.r_data_out_rs1 = rs1_q;
  assign bus.r_data_out_rs2 = rs2_q;

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed vector bench for register_file: table-driven reads/writes plus
// hand-written asynchronous reset sequences.
module tb_register_file;

  import register_file_pkg::*;

  typedef struct {
    logic        we;
    logic        rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  ad;
    logic [31:0] data;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  logic r_clk;
  logic r_rst;
  int   total;
  int   passed;
  vec_t vecs[$];

  register_file_if bus ();

  register_file dut (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .bus   (bus)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  function automatic void push(input logic we, input logic rd,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] ad, input logic [31:0] data,
                               input logic [31:0] exp1, input logic [31:0] exp2);
    vec_t v;
    v.we = we; v.rd = rd; v.a1 = a1; v.a2 = a2; v.ad = ad;
    v.data = data; v.exp1 = exp1; v.exp2 = exp2;
    vecs.push_back(v);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic rd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] ad,
                       input logic [31:0] data);
    bus.r_we        = we;
    bus.r_read_reg  = rd;
    bus.r_addr_rs_1 = a1;
    bus.r_addr_rs_2 = a2;
    bus.r_addr_rd   = ad;
    bus.r_data_rd   = data;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic apply_stimulus(input vec_t v, input int idx);
    drive(v.we, v.rd, v.a1, v.a2, v.ad, v.data);
    @(posedge r_clk);
    #1;
    check_output($sformatf("vec%0d_rs1", idx), bus.r_data_out_rs1, v.exp1);
    check_output($sformatf("vec%0d_rs2", idx), bus.r_data_out_rs2, v.exp2);
  endtask

  initial begin
    total  = 0;
    passed = 0;

    for (int a = 0; a < 32; a++) push(1'b0, 1'b1, 5'(a), 5'(a), 5'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 1; i < 20; i++) push(1'b1, 1'b0, 5'd0, 5'd0, 5'(i), 32'(i), 32'd0, 32'd0);
    for (int i = 0; i <= 10; i++) push(1'b0, 1'b1, 5'(i), 5'(i), 5'd0, 32'd0, 32'(i), 32'(i));
    push(1'b1, 1'b0, 5'd0,  5'd0,  5'd0, 32'hDEADBEEF, 32'd10,     32'd10);
    push(1'b0, 1'b1, 5'd0,  5'd0,  5'd0, 32'd0,        32'd0,      32'd0);
    push(1'b1, 1'b1, 5'd7,  5'd8,  5'd7, 32'h1234,     32'h1234,   32'd8);
    push(1'b0, 1'b1, 5'd7,  5'd7,  5'd0, 32'd0,        32'h1234,   32'h1234);
    push(1'b0, 1'b1, 5'd3,  5'd3,  5'd0, 32'd0,        32'd3,      32'd3);
    push(1'b1, 1'b0, 5'd5,  5'd6,  5'd3, 32'h55,       32'd3,      32'd3);
    push(1'b0, 1'b0, 5'd12, 5'd13, 5'd0, 32'd0,        32'd3,      32'd3);
    push(1'b0, 1'b1, 5'd3,  5'd19, 5'd0, 32'd0,        32'h55,     32'd19);
    push(1'b1, 1'b1, 5'd0,  5'd0,  5'd0, 32'hFFFF,     32'd0,      32'd0);
    push(1'b0, 1'b1, 5'd19, 5'd0,  5'd0, 32'd0,        32'd19,     32'd0);

    r_rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    check_output("reset_rs1", bus.r_data_out_rs1, 32'd0);
    check_output("reset_rs2", bus.r_data_out_rs2, 32'd0);
    repeat (2) @(posedge r_clk);
    #1;
    r_rst = 1'b1;

    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    // Mid-cycle reset: outputs (rs1 currently 19) must clear without an edge.
    r_rst = 1'b0;
    #2;
    check_output("async_clr_rs1", bus.r_data_out_rs1, 32'd0);
    check_output("async_clr_rs2", bus.r_data_out_rs2, 32'd0);

    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 32'hAA);
    @(posedge r_clk);
    #1;
    check_output("rst_edge_rs1", bus.r_data_out_rs1, 32'd0);
    check_output("rst_edge_rs2", bus.r_data_out_rs2, 32'd0);

    // First edge after release must behave normally; register 5 stays cleared.
    r_rst = 1'b1;
    drive(1'b1, 1'b1, 5'd4, 5'd5, 5'd4, 32'h77);
    @(posedge r_clk);
    #1;
    check_output("post_rst_bypass", bus.r_data_out_rs1, 32'h77);
    check_output("post_rst_r5", bus.r_data_out_rs2, 32'd0);

    drive(1'b0, 1'b1, 5'd19, 5'd9, 5'd0, 32'd0);
    @(posedge r_clk);
    #1;
    check_output("post_rst_r19", bus.r_data_out_rs1, 32'd0);
    check_output("post_rst_r9", bus.r_data_out_rs2, 32'd0);

    drive(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 32'd0);
    @(posedge r_clk);
    #1;
    check_output("post_rst_r4_rs1", bus.r_data_out_rs1, 32'h77);
    check_output("post_rst_r4_rs2", bus.r_data_out_rs2, 32'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_register_file
